if_id_skid_buffer: RTL and testbench
====================================

// Module: if_id_skid_buffer
// PURPOSE
//   IF/ID pipeline boundary. Captures {PC, Instruction} from the fetch stage
//   and presents it to decode through a valid/ready handshake.
//   Two-entry skid buffer (output reg + skid reg) so a decode stall never
//   drops a fetched word; back-pressure reaches fetch as freeze = ~if_ready.
//   Branch flush discards all buffered words in one cycle.
// PARAMETERS
//   ADDR_W   32  width of PC field (matches `ADDRESS_LEN)
//   INSTR_W  32  width of instruction field (matches `INSTRUCTION_LEN)
// PORTS
//   clk       in   1        single clock, all state on rising edge
//   rst       in   1        asynchronous, active-low reset
//   flush     in   1        branch taken in EX; discard all buffered entries
//   if_valid  in   1        fetch offers if_pc/if_instr this cycle
//   if_pc     in   ADDR_W   PC+1 of fetched word
//   if_instr  in   INSTR_W  fetched instruction
//   if_ready  out  1        buffer accepts this cycle; fetch freeze = ~if_ready
//   id_valid  out  1        id_pc/id_instr hold a live word
//   id_pc     out  ADDR_W   PC to decode
//   id_instr  out  INSTR_W  instruction to decode
//   id_ready  in   1        decode consumes this cycle (~hazard stall)
//   occupancy out  2        number of live entries, 0..2
// BEHAVIOUR
//   Transfer IF->buf when if_valid & if_ready; buf->ID when id_valid & id_ready.
//   States (occupancy encodes state): EMPTY(0), ONE(1), FULL(2).
//   - EMPTY: id_valid=0, if_ready=1. if_valid -> load out reg, go ONE.
//   - ONE: id_valid=1, if_ready=1.
//       if_valid & id_ready   -> out reg <= input, stay ONE (back-to-back).
//       if_valid & ~id_ready  -> skid reg <= input, go FULL.
//       ~if_valid & id_ready  -> go EMPTY.  neither -> hold.
//   - FULL: id_valid=1, if_ready=0 (input ignored even if if_valid=1).
//       id_ready -> out reg <= skid reg, go ONE.  else hold.
//   if_ready, id_valid, occupancy are decoded from registered state only:
//     no combinational path from id_ready or if_valid to if_ready.
//   Latency: word accepted at edge N appears on id_* after edge N (1 cycle)
//     when ahead of it is empty; order strictly FIFO.
//   flush (synchronous): highest priority; next state EMPTY regardless of
//     if_valid/id_ready in same cycle; the concurrent input word is dropped;
//     data regs keep their old contents (only validity cleared).
//   flush while EMPTY: no effect. flush & id_ready same cycle: the consumed
//     word is still considered taken by decode (handshake already valid).
//   Reset (async, rst=0): state EMPTY, occupancy=0, id_valid=0, if_ready=1,
//     id_pc=0, id_instr=0, skid reg=0; takes effect immediately, mid-transfer
//     words are lost. Release is synchronous to the next clk edge.
//   id_pc/id_instr hold last value while id_valid=0.
//   No arithmetic on data; widths pass through unchanged.
// TESTING
//   1 Reset: drive rst=0 mid-run with occupancy=2 -> same delta: id_valid=0,
//     if_ready=1, occupancy=0, id_pc=0, id_instr=0.
//   2 Streaming: id_ready=1, feed pc 1..4 instr 0xE0000001..4 on 4 edges ->
//     id_* shows each one cycle later, occupancy stays 1, if_ready stays 1.
//   3 Stall: ONE with pc=5; id_ready=0, offer pc=6 -> occupancy=2, if_ready=0;
//     offer pc=7 (ignored); id_ready=1 two cycles -> ID sees 5 then 6, never 7.
//   4 Flush: FULL (pc 8,9) + flush=1 with if_valid=1 pc=10 -> next cycle
//     id_valid=0, occupancy=0, if_ready=1; pc=10 never appears on id_*.
//   5 Flush priority: ONE, if_valid=1, id_ready=0, flush=1 -> EMPTY, not FULL.
//   6 Random: 10k cycles random if_valid/id_ready/flush(5%) vs scoreboard
//     queue -> output order matches, no loss/dup outside flushes, occ<=2.

Source files
------------

// File: rtl/if_id_skid_buffer_if.sv
// IF/ID handshake bundle: fetch-side offer, decode-side consume, flush and occupancy.
// The slave modport is the buffer itself; the master modport drives it (fetch + decode + EX).
interface if_id_skid_buffer_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic               flush;
   logic               if_valid;
   logic [ADDR_W-1:0]  if_pc;
   logic [INSTR_W-1:0] if_instr;
   logic               if_ready;
   logic               id_valid;
   logic [ADDR_W-1:0]  id_pc;
   logic [INSTR_W-1:0] id_instr;
   logic               id_ready;
   logic [1:0]         occupancy;

   modport master (
      output flush, if_valid, if_pc, if_instr, id_ready,
      input  if_ready, id_valid, id_pc, id_instr, occupancy
   );

   modport slave (
      input  flush, if_valid, if_pc, if_instr, id_ready,
      output if_ready, id_valid, id_pc, id_instr, occupancy
   );
endinterface

// File: rtl/if_id_skid_buffer.sv
// IF/ID two-entry skid buffer: 1-cycle latency into an empty buffer, strict FIFO order.
// if_ready drops only when both entries are live; flush empties the buffer in one cycle.
module if_id_skid_buffer #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   if_id_skid_buffer_if.slave   bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             r_state;
   logic [ADDR_W-1:0]  r_out_pc;
   logic [INSTR_W-1:0] r_out_instr;
   logic [ADDR_W-1:0]  r_skid_pc;
   logic [INSTR_W-1:0] r_skid_instr;

   // Handshake outputs decode the registered state only, so no input reaches if_ready.
   assign bus.if_ready  = (r_state != FULL);
   assign bus.id_valid  = (r_state != EMPTY);
   assign bus.occupancy = r_state;
   assign bus.id_pc     = r_out_pc;
   assign bus.id_instr  = r_out_instr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= EMPTY;
         r_out_pc     <= '0;
         r_out_instr  <= '0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
      end else if (bus.flush) begin
         // Only validity is cleared; the concurrent fetch word is dropped.
         r_state <= EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (bus.if_valid) begin
                  r_out_pc    <= bus.if_pc;
                  r_out_instr <= bus.if_instr;
                  r_state     <= ONE;
               end
            end
            ONE: begin
               if (bus.if_valid && bus.id_ready) begin
                  r_out_pc    <= bus.if_pc;
                  r_out_instr <= bus.if_instr;
               end else if (bus.if_valid) begin
                  r_skid_pc    <= bus.if_pc;
                  r_skid_instr <= bus.if_instr;
                  r_state      <= FULL;
               end else if (bus.id_ready) begin
                  r_state <= EMPTY;
               end
            end
            FULL: begin
               if (bus.id_ready) begin
                  r_out_pc    <= r_skid_pc;
                  r_out_instr <= r_skid_instr;
                  r_state     <= ONE;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed scenario tasks plus a randomised run against a FIFO scoreboard.
module tb_if_id_skid_buffer;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   if_id_skid_buffer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   if_id_skid_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hE000_0000 | pc;
   endfunction

   // Drive one cycle of inputs at the falling edge, then step past the rising edge.
   task automatic step(input logic fl, input logic v, input logic [31:0] pc, input logic rdy);
      @(negedge clk);
      bus.flush    = fl;
      bus.if_valid = v;
      bus.if_pc    = pc;
      bus.if_instr = instr_of(pc);
      bus.id_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      bus.flush    = 1'b0;
      bus.if_valid = 1'b0;
      bus.if_pc    = '0;
      bus.if_instr = '0;
      bus.id_ready = 1'b0;
      #1;
      checks++;
      if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1 || bus.occupancy !== 2'd0 ||
          bus.id_pc !== 32'd0 || bus.id_instr !== 32'd0) begin
         errors++;
         $display("FAIL reset_por: got vld=%b rdy=%b occ=%0d pc=%h instr=%h, want 0 1 0 0 0",
                  bus.id_valid, bus.if_ready, bus.occupancy, bus.id_pc, bus.id_instr);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, i, 1'b1);
         checks++;
         if (bus.id_valid !== 1'b1 || bus.id_pc !== i || bus.id_instr !== instr_of(i) ||
             bus.occupancy !== 2'd1 || bus.if_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_%0d: got vld=%b pc=%h instr=%h occ=%0d rdy=%b, want 1 %h %h 1 1",
                     i, bus.id_valid, bus.id_pc, bus.id_instr, bus.occupancy, bus.if_ready,
                     i, instr_of(i));
         end
      end
      step(1'b0, 1'b0, 0, 1'b1);
      checks++;
      if (bus.id_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.id_pc !== 32'd4) begin
         errors++;
         $display("FAIL stream_drain: got vld=%b occ=%0d pc=%h, want 0 0 4",
                  bus.id_valid, bus.occupancy, bus.id_pc);
      end
   endtask

   task automatic test_stall();
      step(1'b0, 1'b1, 5, 1'b0);
      step(1'b0, 1'b1, 6, 1'b0);
      checks++;
      if (bus.occupancy !== 2'd2 || bus.if_ready !== 1'b0 || bus.id_pc !== 32'd5) begin
         errors++;
         $display("FAIL stall_full: got occ=%0d rdy=%b pc=%h, want 2 0 5",
                  bus.occupancy, bus.if_ready, bus.id_pc);
      end
      step(1'b0, 1'b1, 7, 1'b0);
      checks++;
      if (bus.occupancy !== 2'd2 || bus.id_pc !== 32'd5) begin
         errors++;
         $display("FAIL stall_ignore: got occ=%0d pc=%h, want 2 5", bus.occupancy, bus.id_pc);
      end
      step(1'b0, 1'b0, 0, 1'b1);
      checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd6 || bus.id_instr !== instr_of(6) ||
          bus.occupancy !== 2'd1 || bus.if_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_second: got vld=%b pc=%h instr=%h occ=%0d rdy=%b, want 1 6 e0000006 1 1",
                  bus.id_valid, bus.id_pc, bus.id_instr, bus.occupancy, bus.if_ready);
      end
      step(1'b0, 1'b0, 0, 1'b1);
      checks++;
      if (bus.id_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.id_pc !== 32'd6) begin
         errors++;
         $display("FAIL stall_no7: got vld=%b occ=%0d pc=%h, want 0 0 6",
                  bus.id_valid, bus.occupancy, bus.id_pc);
      end
   endtask

   task automatic test_flush();
      step(1'b0, 1'b1, 8, 1'b0);
      step(1'b0, 1'b1, 9, 1'b0);
      step(1'b1, 1'b1, 10, 1'b0);
      checks++;
      if (bus.id_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.if_ready !== 1'b1 ||
          bus.id_pc !== 32'd8) begin
         errors++;
         $display("FAIL flush_full: got vld=%b occ=%0d rdy=%b pc=%h, want 0 0 1 8",
                  bus.id_valid, bus.occupancy, bus.if_ready, bus.id_pc);
      end
      step(1'b0, 1'b0, 0, 1'b1);
      checks++;
      if (bus.id_valid !== 1'b0 || bus.id_pc === 32'd10) begin
         errors++;
         $display("FAIL flush_drop: got vld=%b pc=%h, want 0 and pc not 10", bus.id_valid, bus.id_pc);
      end
      step(1'b1, 1'b0, 0, 1'b0);
      checks++;
      if (bus.occupancy !== 2'd0 || bus.if_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_empty: got occ=%0d rdy=%b, want 0 1", bus.occupancy, bus.if_ready);
      end
   endtask

   task automatic test_flush_priority();
      step(1'b0, 1'b1, 11, 1'b0);
      step(1'b1, 1'b1, 12, 1'b0);
      checks++;
      if (bus.occupancy !== 2'd0 || bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_prio: got occ=%0d vld=%b rdy=%b, want 0 0 1",
                  bus.occupancy, bus.id_valid, bus.if_ready);
      end
   endtask

   task automatic test_reset_midrun();
      step(1'b0, 1'b1, 20, 1'b0);
      step(1'b0, 1'b1, 21, 1'b0);
      checks++;
      if (bus.occupancy !== 2'd2) begin
         errors++;
         $display("FAIL reset_fill: got occ=%0d, want 2", bus.occupancy);
      end
      @(negedge clk);
      bus.if_valid = 1'b0;
      bus.id_ready = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1 || bus.occupancy !== 2'd0 ||
          bus.id_pc !== 32'd0 || bus.id_instr !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: got vld=%b rdy=%b occ=%0d pc=%h instr=%h, want 0 1 0 0 0",
                  bus.id_valid, bus.if_ready, bus.occupancy, bus.id_pc, bus.id_instr);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_random();
      logic [63:0] q[$];
      logic        fl, v, rdy;
      logic [31:0] pc;
      logic [31:0] ins;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         fl  = ($urandom_range(0, 99) < 5);
         v   = 1'($urandom_range(0, 1));
         rdy = 1'($urandom_range(0, 1));
         pc  = $urandom;
         ins = $urandom;
         bus.flush    = fl;
         bus.if_valid = v;
         bus.if_pc    = pc;
         bus.if_instr = ins;
         bus.id_ready = rdy;
         #1;
         checks++;
         if (bus.occupancy !== 2'(q.size()) || bus.id_valid !== (q.size() > 0) ||
             bus.if_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL rand_state cyc %0d: got occ=%0d vld=%b rdy=%b, want occ=%0d",
                     c, bus.occupancy, bus.id_valid, bus.if_ready, q.size());
         end
         if (q.size() > 0) begin
            checks++;
            if ({bus.id_pc, bus.id_instr} !== q[0]) begin
               errors++;
               $display("FAIL rand_data cyc %0d: got %h_%h, want %h",
                        c, bus.id_pc, bus.id_instr, q[0]);
            end
         end
         @(posedge clk);
         if (fl) begin
            q.delete();
         end else begin
            logic acc;
            acc = v && (q.size() < 2);
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back({pc, ins});
         end
      end
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.if_valid = 1'b0;
      bus.id_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_streaming();
      test_stall();
      test_flush();
      test_flush_priority();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
